// File: rtl/arb_pkg.sv
// Shared definitions for the sram-like arbiter: master id encoding,
// transfer size encoding and outstanding-depth defaults.
package arb_pkg;

  // Master id as stored in the response-order FIFO.
  typedef enum logic {
    ID_INST = 1'b0,
    ID_DATA = 1'b1
  } id_e;

  // sram-like transfer size encoding.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Default number of accepted-but-unanswered requests.
  localparam int unsigned OUTSTANDING_DEF = 2;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Response-order FIFO: one id bit per accepted request, popped as the
// downstream answers. DEPTH must be a power of two so pointers wrap naturally.
module arb_id_fifo
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH = OUTSTANDING_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  id_e  din,
  input  logic pop,
  output logic full,
  output logic empty,
  output id_e  head
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  id_e           mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  // Status flags and qualified push/pop.
  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    head    = mem[rd_ptr];
  end

  // Pointer and occupancy tracking; both pointers may advance together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Id storage; contents are only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter (inst fetch vs data access) onto one
// downstream port. Requests and responses pass through combinationally;
// an id FIFO remembers acceptance order to steer responses back.
// Optional macro ARB_RR_EN: round-robin priority instead of data-over-inst.
module sram_like_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING = OUTSTANDING_DEF,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  // instruction master
  input  logic          i_req,
  input  logic          i_wr,
  input  logic [1:0]    i_size,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          i_addr_ok,
  output logic          i_data_ok,
  output logic [DW-1:0] i_rdata,
  // data master
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_addr_ok,
  output logic          d_data_ok,
  output logic [DW-1:0] d_rdata,
  // downstream port
  output logic          s_req,
  output logic          s_wr,
  output logic [1:0]    s_size,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_addr_ok,
  input  logic          s_data_ok,
  input  logic [DW-1:0] s_rdata
);

  id_e  gnt_id;
  id_e  contend_id;
  id_e  lock_id;
  logic lock_vld;
  logic gnt_req;
  logic gnt_addr_ok;
  logic push;
  logic resp_vld;
  logic fifo_full;
  logic fifo_empty;
  id_e  fifo_head;
  logic err_q;
  logic dbg_err_unused;

`ifdef ARB_RR_EN
  id_e last_id;

  // Remember which master was accepted last so the other wins next contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last_id <= ID_INST;
    else if (push) last_id <= gnt_id;
  end

  // Round-robin contention winner.
  always_comb begin
    contend_id = (last_id == ID_DATA) ? ID_INST : ID_DATA;
  end
`else
  // Fixed priority: data wins contention.
  always_comb begin
    contend_id = ID_DATA;
  end
`endif

  // Grant select; a stalled request keeps the grant until accepted.
  always_comb begin
    gnt_id = ID_INST;
    if (lock_vld)            gnt_id = lock_id;
    else if (i_req && d_req) gnt_id = contend_id;
    else if (d_req)          gnt_id = ID_DATA;
    else                     gnt_id = ID_INST;
  end

  // Request mux and addr_ok routing to the granted master.
  always_comb begin
    gnt_req = 1'b0;
    s_wr    = 1'b0;
    s_size  = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (gnt_id == ID_DATA) begin
      gnt_req = d_req;
      s_wr    = d_wr;
      s_size  = d_size;
      s_addr  = d_addr;
      s_wdata = d_wdata;
    end else begin
      gnt_req = i_req;
      s_wr    = i_wr;
      s_size  = i_size;
      s_addr  = i_addr;
      s_wdata = i_wdata;
    end
    s_req       = gnt_req && !fifo_full && !reset;
    gnt_addr_ok = s_addr_ok && !fifo_full && !reset;
    i_addr_ok   = gnt_addr_ok && (gnt_id == ID_INST);
    d_addr_ok   = gnt_addr_ok && (gnt_id == ID_DATA);
    push        = s_req && s_addr_ok;
  end

  // Response routing by FIFO head; responses with nothing outstanding are dropped.
  always_comb begin
    resp_vld  = s_data_ok && !fifo_empty && !reset;
    i_data_ok = resp_vld && (fifo_head == ID_INST);
    d_data_ok = resp_vld && (fifo_head == ID_DATA);
    i_rdata   = s_rdata;
    d_rdata   = s_rdata;
  end

  // Grant lock: hold the presented request stable until the downstream accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld <= 1'b0;
      lock_id  <= ID_INST;
    end else if (push) begin
      lock_vld <= 1'b0;
    end else if (s_req) begin
      lock_vld <= 1'b1;
      lock_id  <= gnt_id;
    end
  end

  // Sticky protocol error: downstream answered with nothing outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        err_q <= 1'b0;
    else if (s_data_ok && fifo_empty) err_q <= 1'b1;
  end

  // The error flag has no port; it is observed hierarchically for debug.
  assign dbg_err_unused = err_q;

  arb_id_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (gnt_id),
    .pop  (resp_vld),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_sram_like_arbiter;

  localparam int unsigned OUT = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic          clk;
  logic          reset;
  logic          i_req, i_wr, d_req, d_wr;
  logic [1:0]    i_size, d_size;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic          i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          s_req, s_wr;
  logic [1:0]    s_size;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_addr_ok, s_data_ok;
  logic [DW-1:0] s_rdata;

  int errors = 0;
  int checks = 0;

  sram_like_arbiter #(
    .OUTSTANDING(OUT),
    .AW(AW),
    .DW(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outstanding requests as a list of issuer ids (0 = inst, 1 = data).
  int q[$];
  bit m_lock;
  int m_lock_id;
  bit m_err;
  int m_pops;
  int m_last;

  function automatic int m_gnt();
    if (m_lock) return m_lock_id;
    if (i_req && d_req) begin
`ifdef ARB_RR_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 1;
`endif
    end
    return d_req ? 1 : 0;
  endfunction

  function automatic bit m_full();
    return q.size() >= OUT;
  endfunction

  function automatic bit m_sreq();
    int g;
    g = m_gnt();
    return !reset && ((g == 1) ? d_req : i_req) && !m_full();
  endfunction

  function automatic bit m_aok(input int who);
    return !reset && s_addr_ok && !m_full() && (m_gnt() == who);
  endfunction

  function automatic bit m_dok(input int who);
    return !reset && s_data_ok && (q.size() > 0) && (q[0] == who);
  endfunction

  int  mu_g;
  bit  mu_sreq;
  bit  mu_acc;

  // Advance the model one clock: accept, then answer, in order.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_lock = 0; m_lock_id = 0; m_err = 0; m_pops = 0; m_last = 0;
    end else begin
      mu_g    = m_gnt();
      mu_sreq = m_sreq();
      mu_acc  = mu_sreq && s_addr_ok;
      if (s_data_ok) begin
        if (q.size() == 0) m_err = 1;
        else begin
          void'(q.pop_front());
          m_pops++;
        end
      end
      if (mu_acc) begin
        q.push_back(mu_g);
        m_lock = 0;
        m_last = mu_g;
      end else if (mu_sreq) begin
        m_lock    = 1;
        m_lock_id = mu_g;
      end
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin : cmp
    int  g;
    bit  sr;
    g  = m_gnt();
    sr = m_sreq();
    check("s_req", s_req, sr);
    check("i_addr_ok", i_addr_ok, m_aok(0));
    check("d_addr_ok", d_addr_ok, m_aok(1));
    if (sr) begin
      check("s_addr",  s_addr,  (g == 1) ? d_addr  : i_addr);
      check("s_wr",    s_wr,    (g == 1) ? d_wr    : i_wr);
      check("s_size",  s_size,  (g == 1) ? d_size  : i_size);
      check("s_wdata", s_wdata, (g == 1) ? d_wdata : i_wdata);
    end
    check("i_data_ok", i_data_ok, m_dok(0));
    check("d_data_ok", d_data_ok, m_dok(1));
    check("i_rdata", i_rdata, s_rdata);
    check("d_rdata", d_rdata, s_rdata);
    check("err", dut.err_q, m_err);
    check("count", dut.u_fifo.count, q.size());
    check("rd_ptr", dut.u_fifo.rd_ptr, m_pops % OUT);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 0; d_req = 0; s_addr_ok = 0; s_data_ok = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  bit acc_i, acc_d;

  initial begin
    reset = 1;
    i_wr = 0; d_wr = 0; i_size = 2'd2; d_size = 2'd2;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; s_rdata = '0;
    idle();
    i_req = 1; s_addr_ok = 1;
    #3;
    check("rst_s_req", s_req, 0);
    check("rst_i_addr_ok", i_addr_ok, 0);
    tick(); tick();
    reset = 0; idle();

    // single inst read
    tick(); i_req = 1; i_addr = 32'hBFC00000; s_addr_ok = 1;
    #2 check("t1_s_addr", s_addr, 32'hBFC00000);
    check("t1_i_addr_ok", i_addr_ok, 1);
    tick(); idle();
    tick(); s_data_ok = 1; s_rdata = 32'h3C1D0001;
    #2 check("t1_i_data_ok", i_data_ok, 1);
    check("t1_i_rdata", i_rdata, 32'h3C1D0001);
    check("t1_d_data_ok", d_data_ok, 0);
    tick(); idle();

    // contention: data first, then inst, responses in that order
    tick(); i_req = 1; d_req = 1; i_addr = 32'hBFC00004; d_addr = 32'h80001000; s_addr_ok = 1;
    #2 check("t2_s_addr", s_addr, 32'h80001000);
    check("t2_d_addr_ok", d_addr_ok, 1);
    check("t2_i_addr_ok", i_addr_ok, 0);
    tick(); d_req = 0;
    #2 check("t2_s_addr2", s_addr, 32'hBFC00004);
    check("t2_i_addr_ok2", i_addr_ok, 1);
    tick(); i_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h11111111;
    #2 check("t2_d_data_ok", d_data_ok, 1);
    check("t2_i_data_ok", i_data_ok, 0);
    tick(); s_rdata = 32'h22222222;
    #2 check("t2_i_data_ok2", i_data_ok, 1);
    check("t2_d_data_ok2", d_data_ok, 0);
    tick(); idle();

    // grant lock: stalled inst request keeps the grant over data
    tick(); i_req = 1; i_addr = 32'hBFC00008; s_addr_ok = 0;
    #2 check("t3_s_addr_c1", s_addr, 32'hBFC00008);
    tick(); d_req = 1; d_addr = 32'h80002000;
    #2 check("t3_s_addr_c2", s_addr, 32'hBFC00008);
    tick();
    #2 check("t3_s_addr_c3", s_addr, 32'hBFC00008);
    tick(); s_addr_ok = 1;
    #2 check("t3_i_addr_ok", i_addr_ok, 1);
    check("t3_d_addr_ok", d_addr_ok, 0);
    check("t3_s_addr_acc", s_addr, 32'hBFC00008);
    tick(); i_req = 0;
    #2 check("t3_s_addr_d", s_addr, 32'h80002000);
    check("t3_d_addr_ok2", d_addr_ok, 1);
    tick(); d_req = 0; s_addr_ok = 0; s_data_ok = 1;
    #2 check("t3_i_data_ok", i_data_ok, 1);
    tick();
    #2 check("t3_d_data_ok", d_data_ok, 1);
    tick(); idle();

    // full: third request blocked, also in the cycle a pop happens
    tick(); i_req = 1; i_addr = 32'hA0000000; s_addr_ok = 1;
    #2 check("t4_acc1", i_addr_ok, 1);
    tick(); i_addr = 32'hA0000004;
    #2 check("t4_acc2", i_addr_ok, 1);
    tick(); i_addr = 32'hA0000008;
    #2 check("t4_full_s_req", s_req, 0);
    check("t4_full_addr_ok", i_addr_ok, 0);
    tick(); s_data_ok = 1;
    #2 check("t4_pop_s_req", s_req, 0);
    check("t4_pop_addr_ok", i_addr_ok, 0);
    check("t4_pop_data_ok", i_data_ok, 1);
    tick(); s_data_ok = 0;
    #2 check("t4_next_s_req", s_req, 1);
    check("t4_next_addr_ok", i_addr_ok, 1);
    tick(); i_req = 0; s_addr_ok = 0; s_data_ok = 1;
    #2 check("t4_drain1", i_data_ok, 1);
    tick();
    #2 check("t4_drain2", i_data_ok, 1);
    tick(); idle();

    // spurious response with nothing outstanding
    tick(); s_data_ok = 1;
    #2 check("t5_i_data_ok", i_data_ok, 0);
    check("t5_d_data_ok", d_data_ok, 0);
    check("t5_err_before", dut.err_q, 0);
    tick(); idle();
    #2 check("t5_err_after", dut.err_q, 1);
    check("t5_count", dut.u_fifo.count, 0);

    // async reset with one request outstanding
    tick(); i_req = 1; i_addr = 32'hBFC00010; s_addr_ok = 1;
    tick(); i_addr = 32'hBFC00014; s_data_ok = 1;
    #1 check("t6_pre_data_ok", i_data_ok, 1);
    #1 reset = 1;
    #1 check("t6_rst_s_req", s_req, 0);
    check("t6_rst_i_addr_ok", i_addr_ok, 0);
    check("t6_rst_d_addr_ok", d_addr_ok, 0);
    check("t6_rst_i_data_ok", i_data_ok, 0);
    tick(); reset = 0; idle(); s_data_ok = 1;
    #2 check("t6_spur_i", i_data_ok, 0);
    check("t6_spur_d", d_data_ok, 0);
    check("t6_err_clear", dut.err_q, 0);
    tick(); idle();
    #2 check("t6_err_set", dut.err_q, 1);

    tick(); reset = 1;
    tick(); reset = 0;

    // randomized traffic; masters hold a request until it is accepted
    acc_i = 0; acc_d = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!i_req || acc_i) begin
        i_req   = ($urandom % 4) != 0;
        i_wr    = ($urandom % 8) == 0;
        i_size  = 2'($urandom_range(2, 0));
        i_addr  = $urandom;
        i_wdata = $urandom;
      end
      if (!d_req || acc_d) begin
        d_req   = ($urandom % 3) != 0;
        d_wr    = $urandom % 2;
        d_size  = 2'($urandom_range(2, 0));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      s_addr_ok = ($urandom % 3) != 0;
      s_data_ok = (q.size() > 0) ? (($urandom % 2) == 1) : (($urandom % 60) == 0);
      s_rdata   = $urandom;
      #3;
      acc_i = i_req && i_addr_ok;
      acc_d = d_req && d_addr_ok;
      tick();
    end

    idle();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
